// File: rtl/approx_arith_pkg.sv
// Shared arithmetic definitions for the approximate adder/subtractor datapaths.
// Holds the default data width, the default approximate/exact split point and
// the full-adder cell functions, so every datapath uses one cell definition.
package approx_arith_pkg;

    localparam int unsigned DATA_W       = 18;
    localparam int unsigned APX_BITS_DEF = 9;

    typedef logic [DATA_W-1:0] data_t;

    // Carry out of a full-adder cell (majority of the three inputs).
    function automatic logic fa_cout(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Sum bit of an exact full-adder cell.
    function automatic logic fa_exact_s(input logic a, input logic b, input logic c);
        return a ^ b ^ c;
    endfunction

    // Sum bit of the approximate cell: the inverted carry stands in for the sum.
    function automatic logic fa_apx_s(input logic a, input logic b, input logic c);
        return ~fa_cout(a, b, c);
    endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational ripple-carry segment built from exact or approximate cells.
// Ports:
//   a    [N-1:0]  first operand slice
//   nb   [N-1:0]  second operand slice (already inverted for subtraction)
//   cin           carry into the lowest bit
//   s    [N-1:0]  segment sum
//   cout          carry out of the highest bit
// Parameter APX selects approximate cells (1) or exact cells (0).
module rca_seg
    import approx_arith_pkg::*;
#(
    parameter int unsigned N   = 1,
    parameter bit          APX = 1'b0
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] nb,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic c;

    // Ripple the carry LSB to MSB; the sum of each bit uses the incoming carry.
    always_comb begin
        s = '0;
        c = cin;
        for (int unsigned i = 0; i < N; i++) begin
            if (APX) begin
                s[i] = fa_apx_s(a[i], nb[i], c);
            end else begin
                s[i] = fa_exact_s(a[i], nb[i], c);
            end
            c = fa_cout(a[i], nb[i], c);
        end
        cout = c;
    end

endmodule

// File: rtl/approx_sub_pipe.sv
// Two-stage pipelined approximate subtractor: D = A - B - Bin = A + ~B + ~Bin.
// Stage 1 ripples the APX_BITS LSBs with approximate cells; stage 2 ripples the
// MSBs with exact cells. Valid/ready handshake on both sides, 1 result/cycle.
// Build option: define APPROX_SUB_EXACT_LSB_EN to make the LSB segment exact
// (bit-exact golden subtractor); handshake, latency and ports are unchanged.
// Ports:
//   i_clk, i_rst_n   clock (rising edge), asynchronous active-low reset
//   i_valid/o_ready  input handshake; o_ready depends combinationally on i_ready
//   i_a, i_b, i_bin  minuend, subtrahend, borrow in
//   o_valid/i_ready  output handshake
//   o_d, o_bout      registered difference and borrow out
module approx_sub_pipe
    import approx_arith_pkg::*;
#(
    parameter int unsigned W        = DATA_W,
    parameter int unsigned APX_BITS = APX_BITS_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_d,
    output logic         o_bout
);

    localparam int unsigned MSB_W = W - APX_BITS;

`ifdef APPROX_SUB_EXACT_LSB_EN
    localparam bit LSB_APX = 1'b0;
`else
    localparam bit LSB_APX = 1'b1;
`endif

    logic                s1_valid_q, s1_valid_d;
    logic [APX_BITS-1:0] s1_lsb_q,   s1_lsb_d;
    logic                s1_c_q,     s1_c_d;
    logic [MSB_W-1:0]    s1_a_hi_q,  s1_a_hi_d;
    logic [MSB_W-1:0]    s1_nb_hi_q, s1_nb_hi_d;
    logic                s2_valid_q, s2_valid_d;
    logic [W-1:0]        d_q,        d_d;
    logic                bout_q,     bout_d;

    logic [APX_BITS-1:0] lsb_sum;
    logic                lsb_cout;
    logic [MSB_W-1:0]    msb_sum;
    logic                msb_cout;
    logic                s2_free;
    logic                s1_adv;
    logic                in_acc;

    // Stage 1 datapath: LSB segment straight from the inputs.
    rca_seg #(
        .N   (APX_BITS),
        .APX (LSB_APX)
    ) u_seg_lsb (
        .a    (i_a[APX_BITS-1:0]),
        .nb   (~i_b[APX_BITS-1:0]),
        .cin  (~i_bin),
        .s    (lsb_sum),
        .cout (lsb_cout)
    );

    // Stage 2 datapath: exact MSB segment from the stage-1 registers.
    rca_seg #(
        .N   (MSB_W),
        .APX (1'b0)
    ) u_seg_msb (
        .a    (s1_a_hi_q),
        .nb   (s1_nb_hi_q),
        .cin  (s1_c_q),
        .s    (msb_sum),
        .cout (msb_cout)
    );

    // Handshake: stage 2 frees up when empty or draining; stage 1 follows.
    assign s2_free = ~s2_valid_q | i_ready;
    assign s1_adv  = s1_valid_q & s2_free;
    assign o_ready = ~s1_valid_q | s2_free;
    assign in_acc  = i_valid & o_ready;

    // Next-state: data registers only load on a transfer into their stage.
    always_comb begin
        s1_valid_d = in_acc | (s1_valid_q & ~s1_adv);
        s1_lsb_d   = s1_lsb_q;
        s1_c_d     = s1_c_q;
        s1_a_hi_d  = s1_a_hi_q;
        s1_nb_hi_d = s1_nb_hi_q;
        s2_valid_d = s1_adv | (s2_valid_q & ~i_ready);
        d_d        = d_q;
        bout_d     = bout_q;

        if (in_acc) begin
            s1_lsb_d   = lsb_sum;
            s1_c_d     = lsb_cout;
            s1_a_hi_d  = i_a[W-1:APX_BITS];
            s1_nb_hi_d = ~i_b[W-1:APX_BITS];
        end

        if (s1_adv) begin
            d_d    = {msb_sum, s1_lsb_q};
            bout_d = ~msb_cout;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_valid_q <= 1'b0;
            s1_lsb_q   <= '0;
            s1_c_q     <= 1'b0;
            s1_a_hi_q  <= '0;
            s1_nb_hi_q <= '0;
            s2_valid_q <= 1'b0;
            d_q        <= '0;
            bout_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_lsb_q   <= s1_lsb_d;
            s1_c_q     <= s1_c_d;
            s1_a_hi_q  <= s1_a_hi_d;
            s1_nb_hi_q <= s1_nb_hi_d;
            s2_valid_q <= s2_valid_d;
            d_q        <= d_d;
            bout_q     <= bout_d;
        end
    end

    assign o_valid = s2_valid_q;
    assign o_d     = d_q;
    assign o_bout  = bout_q;

endmodule

// File: tb/tb_approx_sub_pipe.sv
// Directed and random checks for approx_sub_pipe (either build).
module tb_approx_sub_pipe;

    localparam int unsigned W   = 18;
    localparam int unsigned APX = 9;

`ifdef APPROX_SUB_EXACT_LSB_EN
    localparam bit EXACT = 1'b1;
`else
    localparam bit EXACT = 1'b0;
`endif

    logic         i_clk;
    logic         i_rst_n;
    logic         i_valid;
    logic         o_ready;
    logic [W-1:0] i_a;
    logic [W-1:0] i_b;
    logic         i_bin;
    logic         o_valid;
    logic         i_ready;
    logic [W-1:0] o_d;
    logic         o_bout;

    approx_sub_pipe dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_bin   (i_bin),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_d     (o_d),
        .o_bout  (o_bout)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] d;
        logic         bout;
    } vec_t;

    vec_t tbl[7];
    logic [W:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: returns {bout, d}. LSBs use the approximate cell unless exact build.
    function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic bin);
        logic [W-1:0] nb;
        logic [W-1:0] d;
        logic [W:0]   full;
        logic [W-APX:0] hi;
        logic c;
        logic cn;
        nb = ~b;
        if (EXACT) begin
            full = {1'b0, a} + {1'b0, nb} + (W+1)'(~bin);
            return {~full[W], full[W-1:0]};
        end
        d = '0;
        c = ~bin;
        for (int i = 0; i < int'(APX); i++) begin
            cn   = (a[i] & nb[i]) | (a[i] & c) | (nb[i] & c);
            d[i] = ~cn;
            c    = cn;
        end
        hi = {1'b0, a[W-1:APX]} + {1'b0, nb[W-1:APX]} + (W-APX+1)'(c);
        d[W-1:APX] = hi[W-APX-1:0];
        return {~hi[W-APX], d};
    endfunction

    task automatic next_cycle();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [W:0]   e0, e1, e2;
    logic [W-1:0] held_d;
    logic         held_bout;
    logic         prev_stall;
    logic         acc, cons;
    logic [W:0]   exp_v;

    initial begin
        tbl[0] = '{18'h00000, 18'h00000, 1'b0, 18'h00000, 1'b0};
        tbl[1] = '{18'h00005, 18'h00003, 1'b0, 18'h00002, 1'b0};
        tbl[2] = '{18'h00001, 18'h00000, 1'b0, EXACT ? 18'h00001 : 18'h00000, 1'b0};
        tbl[3] = '{18'h20000, 18'h00001, 1'b0, 18'h1FFFF, 1'b0};
        tbl[4] = '{18'h00000, 18'h00001, 1'b0, 18'h3FFFF, 1'b1};
        tbl[5] = '{18'h00005, 18'h00003, 1'b1, EXACT ? 18'h00001 : 18'h00003, 1'b0};
        tbl[6] = '{18'h3FFFF, 18'h00000, 1'b0, EXACT ? 18'h3FFFF : 18'h3FE00, 1'b0};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_a     = '0;
        i_b     = '0;
        i_bin   = 1'b0;
        @(negedge i_clk);
        @(negedge i_clk);
        chk("rst_o_valid", 32'(o_valid), 32'd0);
        chk("rst_o_d",     32'(o_d),     32'd0);
        chk("rst_o_bout",  32'(o_bout),  32'd0);
        chk("rst_o_ready", 32'(o_ready), 32'd1);
        i_rst_n = 1'b1;
        next_cycle();

        // Table vectors: one at a time, exact 2-cycle latency, then drain.
        for (int k = 0; k < 7; k++) begin
            i_valid = 1'b1;
            i_a     = tbl[k].a;
            i_b     = tbl[k].b;
            i_bin   = tbl[k].bin;
            i_ready = 1'b1;
            next_cycle();
            i_valid = 1'b0;
            chk($sformatf("vec%0d_lat1_valid", k), 32'(o_valid), 32'd0);
            next_cycle();
            chk($sformatf("vec%0d_valid", k), 32'(o_valid), 32'd1);
            chk($sformatf("vec%0d_d", k),     32'(o_d),     32'(tbl[k].d));
            chk($sformatf("vec%0d_bout", k),  32'(o_bout),  32'(tbl[k].bout));
            next_cycle();
            chk($sformatf("vec%0d_drained", k), 32'(o_valid), 32'd0);
        end

        // Backpressure: three back-to-back inputs with the sink stalled.
        e0 = model(18'd100, 18'd30, 1'b0);
        e1 = model(18'd7, 18'd9, 1'b1);
        e2 = model(18'h20000, 18'd1, 1'b0);
        i_ready = 1'b0;
        i_valid = 1'b1; i_a = 18'd100; i_b = 18'd30; i_bin = 1'b0;
        #1 chk("bp_ready0", 32'(o_ready), 32'd1);
        next_cycle();
        i_a = 18'd7; i_b = 18'd9; i_bin = 1'b1;
        #1 chk("bp_ready1", 32'(o_ready), 32'd1);
        next_cycle();
        i_a = 18'h20000; i_b = 18'd1; i_bin = 1'b0;
        #1 chk("bp_full_ready", 32'(o_ready), 32'd0);
        chk("bp_valid", 32'(o_valid), 32'd1);
        chk("bp_d0", 32'({o_bout, o_d}), 32'(e0));
        next_cycle();
        chk("bp_stall_ready", 32'(o_ready), 32'd0);
        chk("bp_d0_stable", 32'({o_bout, o_d}), 32'(e0));
        i_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(o_ready), 32'd1);
        next_cycle();
        i_valid = 1'b0;
        chk("bp_d1_valid", 32'(o_valid), 32'd1);
        chk("bp_d1", 32'({o_bout, o_d}), 32'(e1));
        next_cycle();
        chk("bp_d2_valid", 32'(o_valid), 32'd1);
        chk("bp_d2", 32'({o_bout, o_d}), 32'(e2));
        next_cycle();
        chk("bp_empty", 32'(o_valid), 32'd0);

        // Async reset with both stages full.
        i_ready = 1'b0;
        i_valid = 1'b1; i_a = 18'd11; i_b = 18'd4; i_bin = 1'b0;
        next_cycle();
        i_a = 18'd12;
        next_cycle();
        i_valid = 1'b0;
        #1 chk("full_ready", 32'(o_ready), 32'd0);
        chk("full_valid", 32'(o_valid), 32'd1);
        #1 i_rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(o_valid), 32'd0);
        chk("arst_ready", 32'(o_ready), 32'd1);
        chk("arst_d",     32'(o_d),     32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            chk("arst_no_stale", 32'(o_valid), 32'd0);
        end

        // Random stream with random valid/ready; scoreboard against the model.
        exp_q.delete();
        acc        = 1'b1;
        prev_stall = 1'b0;
        held_d     = '0;
        held_bout  = 1'b0;
        i_valid    = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            if (!i_valid || acc) begin
                i_valid = ($urandom_range(0, 9) < 7);
                i_a     = W'($urandom);
                i_b     = W'($urandom);
                i_bin   = 1'($urandom);
            end
            i_ready = ($urandom_range(0, 9) < 7);
            #1;
            if (prev_stall) begin
                chk("rnd_stable", 32'({o_bout, o_d}), 32'({held_bout, held_d}));
            end
            acc  = i_valid && o_ready;
            cons = o_valid && i_ready;
            if (cons) begin
                if (exp_q.size() == 0) begin
                    chk("rnd_spurious", 32'(o_valid), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("rnd_result", 32'({o_bout, o_d}), 32'(exp_v));
                end
            end
            if (acc) exp_q.push_back(model(i_a, i_b, i_bin));
            prev_stall = o_valid && !i_ready;
            held_d     = o_d;
            held_bout  = o_bout;
            next_cycle();
        end

        // Drain remaining results within a bounded number of cycles.
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            #1;
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    chk("drain_spurious", 32'(o_valid), 32'd0);
                end else begin
                    exp_v = exp_q.pop_front();
                    chk("drain_result", 32'({o_bout, o_d}), 32'(exp_v));
                end
            end
            next_cycle();
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        chk("drain_idle", 32'(o_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
